nn_seq_ctrl: RTL and testbench

NN_SEQ_CTRL -- requirements
Module: nn_seq_ctrl

---
 rtl/nn_ctrl_pkg.sv | 23 ++
 rtl/nn_seq_ctrl_lat_pipe.sv | 31 +++
 rtl/nn_seq_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_nn_seq_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/nn_ctrl_pkg.sv
// nn_ctrl_pkg: shared definitions for the NN sequencer slice.
//   state_e        - controller state encoding
//   DEF_*          - default RAM address width, kernel/weight word counts,
//                    read-pipeline latency
//   N_KERNELS      - kernels read in parallel during classification
package nn_ctrl_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEARN,
    S_CONV,
    S_DRAIN,
    S_FC,
    S_DONE
  } state_e;

  localparam int DEF_NUM_ADDR = 5;
  localparam int DEF_K_WORDS  = 16;
  localparam int DEF_W_WORDS  = 32;
  localparam int DEF_PIPE_LAT = 2;
  localparam int N_KERNELS    = 2;

endpackage

// File: rtl/nn_seq_ctrl_lat_pipe.sv
// nn_lat_pipe: DEPTH-stage shift register, asynchronously cleared.
//   clk_i, rst_i - clock, asynchronous active-high reset
//   d_i          - input bit
//   q_o          - d_i delayed by exactly DEPTH cycles (registered)
module nn_lat_pipe #(
  parameter int DEPTH = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  localparam int unsigned D = DEPTH;

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sr_q <= '0;
    end else begin
      sr_q[0] <= d_i;
      for (int unsigned k = 1; k < D; k++) begin
        sr_q[k] <= sr_q[k-1];
      end
    end
  end

  assign q_o = sr_q[DEPTH-1];

endmodule

// File: rtl/nn_seq_ctrl.sv
// nn_seq_ctrl: sequencer for kernel/weight RAM loading and classification.
//   clk, rst            - clock, asynchronous active-high reset
//   learn, classify     - start pulses, honoured only in IDLE (learn wins)
//   KMEM_ADD1/2, KMEM_{WEB,OEB,CSB}{1,2} - kernel RAM ports (active-low ctl)
//   WMEM_ADD1/2, WMEM_{WEB,OEB,CSB}{1,2} - weight RAM ports (active-low ctl)
//   En                  - pooling enable, PIPE_LAT cycles after each kernel read
//   busy                - high in every state except IDLE
//   done                - one-cycle completion pulse
// Build option: define NN_SEQ_CTRL_FC_EN to add the FC weight-read phase
// after DRAIN; otherwise DRAIN goes straight to DONE.
module nn_seq_ctrl
  import nn_ctrl_pkg::*;
#(
  parameter int NUM_ADDR = DEF_NUM_ADDR,
  parameter int K_WORDS  = DEF_K_WORDS,
  parameter int W_WORDS  = DEF_W_WORDS,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                learn,
  input  logic                classify,
  output logic [NUM_ADDR-1:0] KMEM_ADD1,
  output logic [NUM_ADDR-1:0] KMEM_ADD2,
  output logic                KMEM_WEB1,
  output logic                KMEM_OEB1,
  output logic                KMEM_CSB1,
  output logic                KMEM_WEB2,
  output logic                KMEM_OEB2,
  output logic                KMEM_CSB2,
  output logic [NUM_ADDR-1:0] WMEM_ADD1,
  output logic [NUM_ADDR-1:0] WMEM_ADD2,
  output logic                WMEM_WEB1,
  output logic                WMEM_OEB1,
  output logic                WMEM_CSB1,
  output logic                WMEM_WEB2,
  output logic                WMEM_OEB2,
  output logic                WMEM_CSB2,
  output logic                En,
  output logic                busy,
  output logic                done
);

  localparam int CW = NUM_ADDR + 1;
  localparam logic [CW-1:0] W_HALF = CW'(W_WORDS / 2);
  localparam logic [CW-1:0] K_CNT  = CW'(K_WORDS);
  localparam logic [CW-1:0] P_CNT  = CW'(PIPE_LAT);

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [NUM_ADDR-1:0] kadd1_q, kadd2_q, wadd1_q, wadd2_q;
  logic                k_csb_q, k_web_q, k_oeb_q;
  logic                w_csb_q, w_web_q, w_oeb_q;
  logic                busy_q, done_q;

  logic [NUM_ADDR-1:0] idx;
  logic [NUM_ADDR-1:0] pair_even, pair_odd, k_hi;
  logic                wr_go, krd_go, wrd_go;
  logic                rd_now;

  // Each *_go flag says "the cycle after this edge is an access cycle";
  // the addresses for that cycle are derived from idx. In DRAIN the counter
  // times the drain, so the first FC pair is forced to index 0.
  always_comb begin
    idx    = (state_q == S_DRAIN) ? '0 : cnt_q[NUM_ADDR-1:0];
    wr_go  = 1'b0;
    krd_go = 1'b0;
    wrd_go = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        wr_go  = learn;
        krd_go = classify & ~learn;
      end
      S_LEARN: wr_go  = (cnt_q != W_HALF);
      S_CONV:  krd_go = (cnt_q != K_CNT);
`ifdef NN_SEQ_CTRL_FC_EN
      S_DRAIN: wrd_go = (cnt_q == P_CNT);
      S_FC:    wrd_go = (cnt_q != W_HALF);
`endif
      default: ;
    endcase
  end

  assign pair_even = {idx[NUM_ADDR-2:0], 1'b0};
  assign pair_odd  = {idx[NUM_ADDR-2:0], 1'b1};
  assign k_hi      = idx + NUM_ADDR'(K_WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      kadd1_q <= '0;
      kadd2_q <= '0;
      wadd1_q <= '0;
      wadd2_q <= '0;
      k_csb_q <= 1'b1;
      k_web_q <= 1'b1;
      k_oeb_q <= 1'b1;
      w_csb_q <= 1'b1;
      w_web_q <= 1'b1;
      w_oeb_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      k_csb_q <= 1'b1;
      k_web_q <= 1'b1;
      k_oeb_q <= 1'b1;
      w_csb_q <= 1'b1;
      w_web_q <= 1'b1;
      w_oeb_q <= 1'b1;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;

      unique case (state_q)
        S_IDLE: begin
          if (wr_go)       state_q <= S_LEARN;
          else if (krd_go) state_q <= S_CONV;
          else             busy_q  <= 1'b0;
        end
        S_LEARN: begin
          if (!wr_go) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
        S_CONV: begin
          if (!krd_go) begin
            state_q <= S_DRAIN;
            cnt_q   <= CW'(1);
          end
        end
        S_DRAIN: begin
          if (cnt_q == P_CNT) begin
`ifdef NN_SEQ_CTRL_FC_EN
            state_q <= S_FC;
`else
            state_q <= S_DONE;
            done_q  <= 1'b1;
`endif
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
`ifdef NN_SEQ_CTRL_FC_EN
        S_FC: begin
          if (!wrd_go) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end
        end
`endif
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase

      if (wr_go) begin
        kadd1_q <= pair_even;
        kadd2_q <= pair_odd;
        wadd1_q <= pair_even;
        wadd2_q <= pair_odd;
        k_csb_q <= 1'b0;
        k_web_q <= 1'b0;
        w_csb_q <= 1'b0;
        w_web_q <= 1'b0;
        cnt_q   <= CW'(idx) + CW'(1);
      end
      if (krd_go) begin
        kadd1_q <= idx;
        kadd2_q <= k_hi;
        k_csb_q <= 1'b0;
        k_oeb_q <= 1'b0;
        cnt_q   <= CW'(idx) + CW'(1);
      end
      if (wrd_go) begin
        wadd1_q <= pair_even;
        wadd2_q <= pair_odd;
        w_csb_q <= 1'b0;
        w_oeb_q <= 1'b0;
        cnt_q   <= CW'(idx) + CW'(1);
      end
    end
  end

  // A kernel read is in flight in any cycle with kernel RAM selected for read.
  assign rd_now = ~k_csb_q & ~k_oeb_q;

  nn_lat_pipe #(
    .DEPTH(PIPE_LAT)
  ) u_lat_pipe (
    .clk_i(clk),
    .rst_i(rst),
    .d_i  (rd_now),
    .q_o  (En)
  );

  assign KMEM_ADD1 = kadd1_q;
  assign KMEM_ADD2 = kadd2_q;
  assign KMEM_WEB1 = k_web_q;
  assign KMEM_OEB1 = k_oeb_q;
  assign KMEM_CSB1 = k_csb_q;
  assign KMEM_WEB2 = k_web_q;
  assign KMEM_OEB2 = k_oeb_q;
  assign KMEM_CSB2 = k_csb_q;
  assign WMEM_ADD1 = wadd1_q;
  assign WMEM_ADD2 = wadd2_q;
  assign WMEM_WEB1 = w_web_q;
  assign WMEM_OEB1 = w_oeb_q;
  assign WMEM_CSB1 = w_csb_q;
  assign WMEM_WEB2 = w_web_q;
  assign WMEM_OEB2 = w_oeb_q;
  assign WMEM_CSB2 = w_csb_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_nn_seq_ctrl.sv
// tb_nn_seq_ctrl: directed and random stimulus for nn_seq_ctrl, checked
// cycle by cycle against an operation-level reference model. Honours
// NN_SEQ_CTRL_FC_EN the same way as the design.
module tb_nn_seq_ctrl;

  localparam int NA = 5;
  localparam int K  = 16;
  localparam int W  = 32;
  localparam int P  = 2;

  logic          clk = 1'b0;
  logic          rst, learn, classify;
  logic [NA-1:0] KMEM_ADD1, KMEM_ADD2, WMEM_ADD1, WMEM_ADD2;
  logic          KMEM_WEB1, KMEM_OEB1, KMEM_CSB1, KMEM_WEB2, KMEM_OEB2, KMEM_CSB2;
  logic          WMEM_WEB1, WMEM_OEB1, WMEM_CSB1, WMEM_WEB2, WMEM_OEB2, WMEM_CSB2;
  logic          En, busy, done;

  always #5 clk = ~clk;

  nn_seq_ctrl #(
    .NUM_ADDR(NA),
    .K_WORDS (K),
    .W_WORDS (W),
    .PIPE_LAT(P)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .learn    (learn),
    .classify (classify),
    .KMEM_ADD1(KMEM_ADD1),
    .KMEM_ADD2(KMEM_ADD2),
    .KMEM_WEB1(KMEM_WEB1),
    .KMEM_OEB1(KMEM_OEB1),
    .KMEM_CSB1(KMEM_CSB1),
    .KMEM_WEB2(KMEM_WEB2),
    .KMEM_OEB2(KMEM_OEB2),
    .KMEM_CSB2(KMEM_CSB2),
    .WMEM_ADD1(WMEM_ADD1),
    .WMEM_ADD2(WMEM_ADD2),
    .WMEM_WEB1(WMEM_WEB1),
    .WMEM_OEB1(WMEM_OEB1),
    .WMEM_CSB1(WMEM_CSB1),
    .WMEM_WEB2(WMEM_WEB2),
    .WMEM_OEB2(WMEM_OEB2),
    .WMEM_CSB2(WMEM_CSB2),
    .En       (En),
    .busy     (busy),
    .done     (done)
  );

  // One expected output cycle. kread marks a kernel read (source of En).
  typedef struct packed {
    logic [NA-1:0] k1, k2, w1, w2;
    logic kcs, kwe, koe, wcs, wwe, woe;
    logic kread, en, busy, done;
  } frm_t;

  frm_t q[$];
  frm_t cur;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_done;

  function automatic frm_t idle_f();
    frm_t f;
    f     = '0;
    f.kcs = 1'b1; f.kwe = 1'b1; f.koe = 1'b1;
    f.wcs = 1'b1; f.wwe = 1'b1; f.woe = 1'b1;
    return f;
  endfunction

  // Expand one accepted operation into its full list of output cycles.
  task automatic build(input bit is_learn);
    frm_t f;
    frm_t t;
    if (is_learn) begin
      for (int i = 0; i < W / 2; i++) begin
        f = idle_f(); f.busy = 1'b1;
        f.k1 = NA'(2 * i); f.k2 = NA'(2 * i + 1);
        f.w1 = NA'(2 * i); f.w2 = NA'(2 * i + 1);
        f.kcs = 1'b0; f.kwe = 1'b0; f.wcs = 1'b0; f.wwe = 1'b0;
        q.push_back(f);
      end
    end else begin
      for (int j = 0; j < K; j++) begin
        f = idle_f(); f.busy = 1'b1;
        f.k1 = NA'(j); f.k2 = NA'(K + j);
        f.kcs = 1'b0; f.koe = 1'b0; f.kread = 1'b1;
        q.push_back(f);
      end
      for (int d = 0; d < P; d++) begin
        f = idle_f(); f.busy = 1'b1;
        q.push_back(f);
      end
`ifdef NN_SEQ_CTRL_FC_EN
      for (int i = 0; i < W / 2; i++) begin
        f = idle_f(); f.busy = 1'b1;
        f.w1 = NA'(2 * i); f.w2 = NA'(2 * i + 1);
        f.wcs = 1'b0; f.woe = 1'b0;
        q.push_back(f);
      end
`endif
    end
    f = idle_f(); f.busy = 1'b1; f.done = 1'b1;
    q.push_back(f);
    for (int n = P; n < q.size(); n++) begin
      t    = q[n];
      t.en = q[n - P].kread;
      q[n] = t;
    end
  endtask

  task automatic check_frame();
    logic [4*NA+14:0] o, e;
    o = {cur.kcs ? {NA{1'b0}} : KMEM_ADD1, cur.kcs ? {NA{1'b0}} : KMEM_ADD2,
         cur.wcs ? {NA{1'b0}} : WMEM_ADD1, cur.wcs ? {NA{1'b0}} : WMEM_ADD2,
         KMEM_CSB1, KMEM_WEB1, KMEM_OEB1, KMEM_CSB2, KMEM_WEB2, KMEM_OEB2,
         WMEM_CSB1, WMEM_WEB1, WMEM_OEB1, WMEM_CSB2, WMEM_WEB2, WMEM_OEB2,
         En, busy, done};
    e = {cur.k1, cur.k2, cur.w1, cur.w2,
         cur.kcs, cur.kwe, cur.koe, cur.kcs, cur.kwe, cur.koe,
         cur.wcs, cur.wwe, cur.woe, cur.wcs, cur.wwe, cur.woe,
         cur.en, cur.busy, cur.done};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL frame cyc=%0d got=%h exp=%h", cyc, o, e);
    end
    checks++;
    assert ({KMEM_WEB1 | KMEM_OEB1, KMEM_WEB2 | KMEM_OEB2,
             WMEM_WEB1 | WMEM_OEB1, WMEM_WEB2 | WMEM_OEB2} === 4'b1111) else begin
      failures++;
      $error("FAIL web_oeb_conflict cyc=%0d got=%b%b%b%b%b%b%b%b exp=no port with WEB=0,OEB=0",
             cyc, KMEM_WEB1, KMEM_OEB1, KMEM_WEB2, KMEM_OEB2,
             WMEM_WEB1, WMEM_OEB1, WMEM_WEB2, WMEM_OEB2);
    end
    checks++;
    assert ((prev_done & done) === 1'b0) else begin
      failures++;
      $error("FAIL done_twice cyc=%0d got=prev%b,now%b exp=not both 1", cyc, prev_done, done);
    end
    prev_done = done;
  endtask

  task automatic check_reset(input string tag);
    logic [4*NA+14:0] o, e;
    o = {KMEM_ADD1, KMEM_ADD2, WMEM_ADD1, WMEM_ADD2,
         KMEM_CSB1, KMEM_WEB1, KMEM_OEB1, KMEM_CSB2, KMEM_WEB2, KMEM_OEB2,
         WMEM_CSB1, WMEM_WEB1, WMEM_OEB1, WMEM_CSB2, WMEM_WEB2, WMEM_OEB2,
         En, busy, done};
    e = {{(4*NA){1'b0}}, 12'hFFF, 3'b000};
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, o, e);
    end
  endtask

  // One clock: drive inputs, let the model advance at the edge, compare.
  task automatic step(input logic l, input logic c);
    learn    = l;
    classify = c;
    @(posedge clk);
    cyc++;
    if (q.size() > 0) cur = q.pop_front();
    else if (!cur.busy && (l || c)) begin
      build(l);
      cur = q.pop_front();
    end else cur = idle_f();
    #1;
    check_frame();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check_reset("reset_async");
    q.delete();
    cur       = idle_f();
    prev_done = 1'b0;
    @(posedge clk);
    #1;
    check_reset("reset_held");
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    learn     = 1'b0;
    classify  = 1'b0;
    cur       = idle_f();
    prev_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset("reset_state");
    rst = 1'b0;

    // learn accepted on the first edge after reset release
    step(1'b1, 1'b0);
    repeat (20) step(1'b0, 1'b0);

    // learn and classify together, then classify held during LEARN
    step(1'b1, 1'b1);
    repeat (8) step(1'b0, 1'b1);
    repeat (12) step(1'b0, 1'b0);

    // plain classify
    step(1'b0, 1'b1);
    repeat (45) step(1'b0, 1'b0);

    // abort at CONV cycle 5, then restart
    step(1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0);
    apply_reset();
    step(1'b0, 1'b1);
    repeat (45) step(1'b0, 1'b0);

    // random start pulses, including ones that must be ignored
    for (int i = 0; i < 1200; i++) begin
      if (i == 600) apply_reset();
      step($urandom_range(0, 11) == 0, $urandom_range(0, 11) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
